// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell, a registered carry, LSB first.
// Operands are captured on start. The sum appears together with a one-cycle done pulse.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Only the upper WIDTH-1 partial bits are kept; the final bit goes straight into sum.
  logic [WIDTH-2:0] s_sh;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nxt;
  logic [WIDTH-1:0] s_nxt;

  fulladder u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(c), .s(s_bit), .co(c_nxt));

  assign s_nxt = {s_bit, s_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= (WIDTH-1)'(s_nxt >> 1);
          c    <= c_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= s_nxt;
            cout  <= c_nxt;
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder at WIDTH=8.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  int tests = 0;
  int fails = 0;
  logic [7:0] last_sum  = 8'h00;
  logic       last_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  // One transaction: start pulse, WIDTH busy cycles, done pulse, return to idle.
  task automatic do_add(input logic [7:0] xa, input logic [7:0] xb, input bit inject,
                        input string name);
    logic [8:0] exp;
    bit busy_ok, hold_ok;
    exp = {1'b0, xa} + {1'b0, xb};
    busy_ok = 1;
    hold_ok = 1;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
      if (sum !== last_sum || cout !== last_cout) hold_ok = 0;
      if (inject && i == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (!busy_ok) begin
      fails++; $display("FAIL %s busy_window: busy/done not 1/0 for all 8 SHIFT cycles", name);
    end
    tests++;
    if (!hold_ok) begin
      fails++; $display("FAIL %s hold: sum/cout changed during SHIFT, required %h/%b", name, last_sum, last_cout);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s done_edge: done=%b busy=%b, required 1/0", name, done, busy);
    end
    tests++;
    if ({cout, sum} !== exp) begin
      fails++; $display("FAIL %s result: got %h, required %h (a=%h b=%h)", name, {cout, sum}, exp, xa, xb);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s after_done: done=%b busy=%b, required 0/0", name, done, busy);
    end
    last_sum  = exp[7:0];
    last_cout = exp[8];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    #2;
    tests++;
    if ({busy, done, cout, sum} !== 11'b0) begin
      fails++; $display("FAIL reset_async: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, cout, sum} !== 11'b0) begin
      fails++; $display("FAIL reset_idle: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
    end
  endtask

  task automatic test_zero();
    do_add(8'h00, 8'h00, 0, "zero");
  endtask

  task automatic test_ripple();
    do_add(8'hFF, 8'h01, 0, "ripple_ff_01");
    do_add(8'hFF, 8'hFF, 0, "ripple_ff_ff");
    do_add(8'hA5, 8'h5A, 0, "ripple_a5_5a");
  endtask

  task automatic test_start_ignored();
    do_add(8'h10, 8'h20, 1, "start_ignored");
    // A queued start would show up as busy in the following idle cycles.
    begin
      bit idle_ok = 1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) idle_ok = 0;
      end
      tests++;
      if (!idle_ok) begin
        fails++; $display("FAIL start_ignored_not_queued: activity seen after done, required idle");
      end
    end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1;
    @(negedge clk);
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, cout, sum} !== 11'b0) begin
      fails++; $display("FAIL reset_mid: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    tests++;
    if (!quiet) begin
      fails++; $display("FAIL reset_mid_quiet: busy or done seen after reset, required none");
    end
    last_sum = 8'h00; last_cout = 1'b0;
    do_add(8'h03, 8'h04, 0, "after_reset");
  endtask

  task automatic test_continuous();
    int npulse = 0;
    int prev = -1;
    bit gap_ok = 1, res_ok = 1;
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        npulse++;
        if ({cout, sum} !== 9'h100) res_ok = 0;
        if (prev >= 0 && k - prev != 10) gap_ok = 0;
        if (prev < 0 && k != 8) gap_ok = 0;
        prev = k;
      end
    end
    start = 1'b0;
    tests++;
    if (npulse != 3) begin
      fails++; $display("FAIL continuous_count: got %0d done pulses, required 3", npulse);
    end
    tests++;
    if (!gap_ok) begin
      fails++; $display("FAIL continuous_spacing: done pulses not at cycles 8,18,28");
    end
    tests++;
    if (!res_ok) begin
      fails++; $display("FAIL continuous_result: a result differed from 100");
    end
    @(negedge clk); @(negedge clk);
    last_sum = 8'h00; last_cout = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      do_add(8'($urandom), 8'($urandom), 0, "random");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ripple();
    test_start_ignored();
    test_reset_mid();
    test_continuous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
